// File: rtl/period_sync_generator.sv
// Period boundary generator: counts decimated sample strobes and emits a one-cycle
// counter_reset at each period boundary, free-running or aligned to an external sync edge.
module period_sync_generator #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             enable,
    input  logic             sync_mode,
    input  logic             sample_valid,
    input  logic [CNT_W-1:0] period_length,
    input  logic             resync,
    input  logic             ext_sync,
    input  logic             clear_error,
    output logic             counter_reset,
    output logic [CNT_W-1:0] sample_index,
    output logic [CNT_W-1:0] period_count,
    output logic             running,
    output logic             sync_error
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitSync,
        StRun
    } state_t;

    localparam logic [CNT_W-1:0] MinLen = CNT_W'(2);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_last;
    logic                   r_sync_edge;

    state_t                 r_state;
    logic                   r_ext_mode;
    logic [CNT_W-1:0]       r_len;
    logic [CNT_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_counter_reset;
    logic                   r_cr_d1;
    logic                   r_running;
    logic                   r_sync_error;

    logic [CNT_W-1:0]       w_len_in;
    logic                   w_last;
    logic                   w_boundary_sample;
    logic                   w_near_pulse;
    logic                   w_misaligned;
    logic                   w_err_set;
    logic [CNT_W-1:0]       w_idx_inc;
    logic [CNT_W-1:0]       w_cnt_inc;

    // Synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_sync      <= '0;
            r_sync_last <= 1'b0;
            r_sync_edge <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], ext_sync};
            r_sync_last <= r_sync[SYNC_STAGES-1];
            r_sync_edge <= r_sync[SYNC_STAGES-1] & ~r_sync_last;
        end
    end

    assign w_len_in          = (period_length < MinLen) ? MinLen : period_length;
    assign w_last            = (r_idx == (r_len - One));
    assign w_boundary_sample = sample_valid & w_last;
    // An edge right at or just after a boundary pulse is the same boundary, not a slip.
    assign w_near_pulse      = (r_idx == '0) & (r_counter_reset | r_cr_d1);
    assign w_misaligned      = r_ext_mode & r_sync_edge & ~w_boundary_sample & ~w_near_pulse;
    assign w_err_set         = enable & (r_state == StRun) & ~resync & w_misaligned;
    assign w_idx_inc         = r_idx + One;
    assign w_cnt_inc         = r_cnt + One;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state         <= StIdle;
            r_ext_mode      <= 1'b0;
            r_len           <= MinLen;
            r_idx           <= '0;
            r_cnt           <= '0;
            r_counter_reset <= 1'b0;
            r_cr_d1         <= 1'b0;
            r_running       <= 1'b0;
            r_sync_error    <= 1'b0;
        end else begin
            r_counter_reset <= 1'b0;
            r_cr_d1         <= r_counter_reset;

            if (w_err_set) begin
                r_sync_error <= 1'b1;
            end else if (clear_error) begin
                r_sync_error <= 1'b0;
            end

            if (!enable) begin
                r_state   <= StIdle;
                r_idx     <= '0;
                r_cnt     <= '0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_ext_mode <= sync_mode;
                        if (sync_mode) begin
                            r_state <= StWaitSync;
                        end else begin
                            r_state         <= StRun;
                            r_running       <= 1'b1;
                            r_len           <= w_len_in;
                            r_idx           <= '0;
                            r_cnt           <= '0;
                            r_counter_reset <= 1'b1;
                        end
                    end
                    StWaitSync: begin
                        if (r_sync_edge) begin
                            r_state         <= StRun;
                            r_running       <= 1'b1;
                            r_len           <= w_len_in;
                            r_idx           <= '0;
                            r_cnt           <= '0;
                            r_counter_reset <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (resync) begin
                            r_idx <= '0;
                            r_cnt <= '0;
                            if (r_ext_mode) begin
                                r_state   <= StWaitSync;
                                r_running <= 1'b0;
                            end else begin
                                r_len           <= w_len_in;
                                // Keeps the pulse from stretching across two cycles.
                                r_counter_reset <= ~r_counter_reset;
                            end
                        end else if (w_misaligned || w_boundary_sample) begin
                            r_idx           <= '0;
                            r_cnt           <= w_cnt_inc;
                            r_len           <= w_len_in;
                            r_counter_reset <= 1'b1;
                        end else if (sample_valid) begin
                            r_idx <= w_idx_inc;
                        end
                    end
                    default: begin
                        r_state   <= StIdle;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign counter_reset = r_counter_reset;
    assign sample_index  = r_idx;
    assign period_count  = r_cnt;
    assign running       = r_running;
    assign sync_error    = r_sync_error;

endmodule

// File: tb/tb_period_sync_generator.sv
// Bench for period_sync_generator: directed scenarios with literal expectations, then
// randomized stimulus checked every cycle against a behavioural model.
module tb_period_sync_generator;

    localparam int CW = 4;
    localparam int SS = 2;
    localparam int HL = SS + 3;
    localparam int PIdle = 0;
    localparam int PWait = 1;
    localparam int PRun  = 2;

    logic          clk = 1'b0;
    logic          areset;
    logic          enable;
    logic          sync_mode;
    logic          sample_valid;
    logic [CW-1:0] period_length;
    logic          resync;
    logic          ext_sync;
    logic          clear_error;
    logic          counter_reset;
    logic [CW-1:0] sample_index;
    logic [CW-1:0] period_count;
    logic          running;
    logic          sync_error;

    int n_cmp  = 0;
    int n_fail = 0;

    period_sync_generator #(
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .enable        (enable),
        .sync_mode     (sync_mode),
        .sample_valid  (sample_valid),
        .period_length (period_length),
        .resync        (resync),
        .ext_sync      (ext_sync),
        .clear_error   (clear_error),
        .counter_reset (counter_reset),
        .sample_index  (sample_index),
        .period_count  (period_count),
        .running       (running),
        .sync_error    (sync_error)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase, position in period, periods done, and the ext_sync history
    // (a rise becomes visible to the control logic SS+2 clocks after it is first sampled).
    int m_phase, m_len, m_idx, m_cnt;
    bit m_ext, m_err, m_pulse, m_pulse_prev, m_next;
    bit hist[HL];

    function automatic int clamp_len(input int l);
        return (l < 2) ? 2 : l;
    endfunction

    task automatic m_reset();
        m_phase = PIdle; m_len = 2; m_idx = 0; m_cnt = 0;
        m_ext = 0; m_err = 0; m_pulse = 0; m_pulse_prev = 0;
        for (int i = 0; i < HL; i++) hist[i] = 1'b0;
    endtask

    task automatic m_start();
        m_phase = PRun; m_idx = 0; m_cnt = 0;
        m_len = clamp_len(int'(period_length)); m_next = 1;
    endtask

    task automatic m_wrap();
        m_idx = 0; m_cnt = (m_cnt + 1) % (1 << CW);
        m_len = clamp_len(int'(period_length)); m_next = 1;
    endtask

    task automatic m_advance();
        if (m_idx < m_len - 1) m_idx = m_idx + 1;
        else m_wrap();
    endtask

    task automatic m_step();
        bit sedge, prev, prev2, err_set;
        for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = ext_sync;
        sedge   = hist[SS+1] && !hist[SS+2];
        prev    = m_pulse;
        prev2   = m_pulse_prev;
        m_next  = 0;
        err_set = 0;
        if (!enable) begin
            m_phase = PIdle; m_idx = 0; m_cnt = 0;
        end else if (m_phase == PIdle) begin
            m_ext = sync_mode;
            if (sync_mode) m_phase = PWait;
            else m_start();
        end else if (m_phase == PWait) begin
            if (sedge) m_start();
        end else begin
            if (resync) begin
                m_idx = 0; m_cnt = 0;
                if (m_ext) m_phase = PWait;
                else begin
                    m_len = clamp_len(int'(period_length));
                    m_next = !prev;
                end
            end else if (m_ext && sedge) begin
                if (sample_valid && m_idx == m_len - 1) m_wrap();
                else if (m_idx == 0 && (prev || prev2)) begin
                    if (sample_valid) m_advance();
                end else begin
                    err_set = 1;
                    m_wrap();
                end
            end else if (sample_valid) begin
                m_advance();
            end
        end
        if (err_set) m_err = 1;
        else if (clear_error) m_err = 0;
        m_pulse_prev = prev;
        m_pulse      = m_next;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge areset);
            if (areset) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!areset) begin
                cmp("model counter_reset", int'(counter_reset), int'(m_pulse));
                cmp("model running", int'(running), int'(m_phase == PRun));
                cmp("model sample_index", int'(sample_index), m_idx);
                cmp("model period_count", int'(period_count), m_cnt);
                cmp("model sync_error", int'(sync_error), int'(m_err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        cmp({tag, " counter_reset"}, int'(counter_reset), 0);
        cmp({tag, " running"}, int'(running), 0);
        cmp({tag, " sample_index"}, int'(sample_index), 0);
        cmp({tag, " period_count"}, int'(period_count), 0);
        cmp({tag, " sync_error"}, int'(sync_error), 0);
    endtask

    initial begin
        areset = 1'b1; enable = 1'b0; sync_mode = 1'b0; sample_valid = 1'b0;
        period_length = '0; resync = 1'b0; ext_sync = 1'b0; clear_error = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        areset = 1'b0;
        step();
        cmp("post-reset counter_reset", int'(counter_reset), 0);
        cmp("post-reset running", int'(running), 0);

        // Internal free-run, length 5, a sample every 4th clock.
        sync_mode = 1'b0; period_length = 4'd5; enable = 1'b1;
        step();
        cmp("entry pulse", int'(counter_reset), 1);
        cmp("entry running", int'(running), 1);
        cmp("entry index", int'(sample_index), 0);
        for (int i = 0; i < 12; i++) begin
            repeat (3) step();
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            cmp("free-run pulse", int'(counter_reset), int'(i % 5 == 4));
            cmp("free-run index", int'(sample_index), (i + 1) % 5);
            cmp("free-run count", int'(period_count), (i + 1) / 5);
        end

        // Asynchronous reset while running with samples every cycle.
        sample_valid = 1'b1;
        step();
        step();
        #2 areset = 1'b1;
        #1;
        chk_all_zero("async reset");
        enable = 1'b0; sample_valid = 1'b0;
        step();
        cmp("reset hold running", int'(running), 0);
        areset = 1'b0;
        step();
        cmp("release counter_reset", int'(counter_reset), 0);
        cmp("release running", int'(running), 0);

        // Length clamp: period_length=1 behaves as 2.
        period_length = 4'd1; enable = 1'b1;
        step();
        cmp("clamp entry pulse", int'(counter_reset), 1);
        sample_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            cmp("clamp pulse", int'(counter_reset), int'(i % 2 == 0));
            cmp("clamp index", int'(sample_index), i % 2);
            cmp("clamp count", int'(period_count), i / 2);
        end
        sample_valid = 1'b0;

        // Shadow length: change 8->3 mid-period takes effect at the next boundary.
        enable = 1'b0;
        step();
        period_length = 4'd8; enable = 1'b1;
        step();
        sample_valid = 1'b1;
        repeat (4) step();
        cmp("shadow index 4", int'(sample_index), 4);
        period_length = 4'd3;
        repeat (3) step();
        cmp("shadow index 7", int'(sample_index), 7);
        cmp("shadow no early pulse", int'(counter_reset), 0);
        step();
        cmp("shadow boundary pulse", int'(counter_reset), 1);
        cmp("shadow boundary count", int'(period_count), 1);
        repeat (2) step();
        cmp("shadow short index", int'(sample_index), 2);
        step();
        cmp("shadow short pulse", int'(counter_reset), 1);
        cmp("shadow short count", int'(period_count), 2);
        sample_valid = 1'b0;

        // External sync, aligned.
        enable = 1'b0;
        step();
        sync_mode = 1'b1; period_length = 4'd10; enable = 1'b1;
        step();
        cmp("wait running", int'(running), 0);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        cmp("wait ignores sample", int'(sample_index), 0);
        ext_sync = 1'b1;
        for (int i = 0; i < SS + 1; i++) begin
            step();
            cmp("ext entry early", int'(counter_reset), 0);
        end
        step();
        cmp("ext entry pulse", int'(counter_reset), 1);
        cmp("ext entry running", int'(running), 1);
        ext_sync = 1'b0;
        sample_valid = 1'b1;
        repeat (9) step();
        sample_valid = 1'b0;
        cmp("ext index 9", int'(sample_index), 9);
        ext_sync = 1'b1;
        repeat (SS + 1) step();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        cmp("aligned pulse", int'(counter_reset), 1);
        cmp("aligned no error", int'(sync_error), 0);
        cmp("aligned count", int'(period_count), 1);
        ext_sync = 1'b0;
        step();
        cmp("aligned single pulse", int'(counter_reset), 0);

        // External sync, misaligned at index 6.
        sample_valid = 1'b1;
        repeat (6) step();
        sample_valid = 1'b0;
        cmp("misalign index 6", int'(sample_index), 6);
        ext_sync = 1'b1;
        repeat (SS + 1) step();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        cmp("misalign error", int'(sync_error), 1);
        cmp("misalign index", int'(sample_index), 0);
        cmp("misalign count", int'(period_count), 2);
        cmp("misalign pulse", int'(counter_reset), 1);
        ext_sync = 1'b0;
        step();
        cmp("misalign single pulse", int'(counter_reset), 0);
        cmp("misalign sample dropped", int'(sample_index), 0);
        clear_error = 1'b1;
        step();
        clear_error = 1'b0;
        cmp("clear error", int'(sync_error), 0);
        sample_valid = 1'b1;
        repeat (3) step();
        sample_valid = 1'b0;
        ext_sync = 1'b1;
        repeat (SS + 1) step();
        clear_error = 1'b1;
        step();
        clear_error = 1'b0;
        ext_sync = 1'b0;
        cmp("set beats clear", int'(sync_error), 1);
        cmp("set beats clear count", int'(period_count), 3);

        // Control priority, internal mode.
        enable = 1'b0;
        step();
        cmp("error survives disable", int'(sync_error), 1);
        sync_mode = 1'b0; period_length = 4'd4; enable = 1'b1;
        step();
        sample_valid = 1'b1;
        repeat (3) step();
        cmp("resync pre index", int'(sample_index), 3);
        resync = 1'b1;
        step();
        resync = 1'b0; sample_valid = 1'b0;
        cmp("resync count", int'(period_count), 0);
        cmp("resync pulse", int'(counter_reset), 1);
        step();
        cmp("resync single pulse", int'(counter_reset), 0);
        sample_valid = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        step();
        sample_valid = 1'b0;
        cmp("disable suppresses pulse", int'(counter_reset), 0);
        cmp("disable running", int'(running), 0);
        cmp("disable index", int'(sample_index), 0);
        cmp("disable count", int'(period_count), 0);
        period_length = 4'd2; enable = 1'b1;
        step();
        sample_valid = 1'b1;
        repeat (30) step();
        cmp("wrap count 15", int'(period_count), 15);
        repeat (2) step();
        sample_valid = 1'b0;
        cmp("wrap count 0", int'(period_count), 0);
        cmp("wrap pulse", int'(counter_reset), 1);

        // Randomized phase; the compare process checks every cycle.
        clear_error = 1'b1;
        step();
        for (int c = 0; c < 4000; c++) begin
            enable        = ($urandom_range(0, 99) != 0);
            sync_mode     = 1'($urandom_range(0, 1));
            sample_valid  = ($urandom_range(0, 2) != 0);
            resync        = ($urandom_range(0, 59) == 0);
            clear_error   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) period_length = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ext_sync = ~ext_sync;
            if ($urandom_range(0, 799) == 0) begin
                #2 areset = 1'b1;
                #5 areset = 1'b0;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/period_sync_generator.md
Name: period_sync_generator

Overview:
- Upstream of the counter-delayed trigger stage; generates its `counter_reset` period-boundary pulse.
- Counts decimated ADC sample strobes and emits a one-cycle boundary pulse every `period_length` samples.
- Exposes the running sample index and period number.
- Free-runs from an internal start, or aligns to an external sync input with misalignment detection.

Parameters:
- CNT_W, 32, width of period_length, sample_index, period_count.
- SYNC_STAGES, 2, synchronizer flops on ext_sync (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- areset  in  1  asynchronous reset, active-high.
- enable  in  1  level; 1 = generator active, 0 = return to IDLE.
- sync_mode  in  1  0 = internal start, 1 = wait for and track ext_sync; sampled only in IDLE.
- sample_valid  in  1  one-cycle strobe per decimated sample.
- period_length  in  CNT_W  samples per period; shadow-latched.
- resync  in  1  one-cycle restart request.
- ext_sync  in  1  asynchronous external sync, rising-edge active.
- clear_error  in  1  clears sync_error.
- counter_reset  out  1  one-cycle period-boundary pulse.
- sample_index  out  CNT_W  index of next sample within period.
- period_count  out  CNT_W  completed periods since start; wraps at 2^CNT_W.
- running  out  1  high in RUN.
- sync_error  out  1  sticky external-sync misalignment flag.

Behaviour:
- areset=1 (asynchronous) forces:
  - state IDLE
  - all outputs 0
  - synchronizer and edge-detect flops 0
  - length shadow 2
- ext_sync path: SYNC_STAGES-flop synchronizer, then rising-edge detect.
  - sync_edge is high for exactly one cycle, SYNC_STAGES+1 cycles after the ext_sync rise.
- Length shadow:
  - len = max(period_length, 2).
  - Latched on entry to RUN and at every boundary. A change mid-period takes effect at the next boundary.
- Priority each cycle: enable=0 > resync > sync_edge > sample_valid.
- IDLE: sample_index=0, period_count=0, running=0.
  - enable=1 and sync_mode=0 -> RUN.
  - enable=1 and sync_mode=1 -> WAIT_SYNC (mode latched).
- Entry to RUN:
  - sample_index=0, period_count=0, running=1.
  - counter_reset=1 for one cycle, registered with the state change, i.e. 1 cycle after the enable or sync_edge cycle.
- WAIT_SYNC:
  - running=0; sample_valid ignored.
  - sync_edge -> RUN (entry pulse).
  - enable=0 -> IDLE.
- RUN, sample_valid:
  - If sample_index < len-1: sample_index+1.
  - Else: sample_index=0, period_count+1 (mod 2^CNT_W), shadow reloaded, counter_reset=1 on the following cycle.
  - Boundary pulse latency: 1 clk after the completing sample_valid.
- RUN, external mode, sync_edge:
  - Aligned case: the same cycle is a boundary (sample_valid at len-1), or sample_index==0 within 1 cycle after a boundary pulse. Treat as the normal boundary, no extra pulse, no error.
  - Otherwise: set sync_error, then realign:
    - sample_index=0, period_count+1.
    - counter_reset pulse next cycle.
    - that cycle's sample_valid is discarded.
- RUN, internal mode: sync_edge ignored.
- resync in RUN (either mode):
  - period_count=0, sample_index=0, no error change.
  - Internal mode: counter_reset pulse next cycle, stay in RUN.
  - External mode: -> WAIT_SYNC, running=0, no pulse.
- resync in IDLE or WAIT_SYNC: no effect.
- enable=0 in any state: -> IDLE next cycle.
  - Counters cleared, no pulse.
  - A pending boundary pulse from the same cycle is suppressed.
- sync_error:
  - Set dominates clear_error in the same cycle.
  - Cleared only by clear_error or areset; survives enable toggling.
- counter_reset is never high on two consecutive cycles.

Test Plan:
- Reset: hold areset=1 mid-RUN with sample_valid every cycle -> all outputs 0 within the same cycle. Release -> IDLE, no pulse.
- Internal free-run: sync_mode=0, period_length=5, sample_valid every 4th clk, enable=1.
  - Entry pulse 1 clk after enable.
  - Thereafter pulse 1 clk after every 5th sample_valid.
  - sample_index cycles 0..4; period_count 0,1,2,…
- Length clamp and shadow:
  - period_length=1 -> boundaries every 2 samples.
  - Change period_length 8->3 at sample_index=4 -> current period still ends after 8 samples, next after 3.
- External sync, aligned: sync_mode=1, period_length=10, ext_sync rise.
  - counter_reset pulses SYNC_STAGES+2 clks after the rise.
  - A later ext_sync edge landing exactly on a boundary -> single pulse, sync_error=0.
- External sync, misaligned: edge at sample_index=6 of len 10.
  - sync_error=1, sample_index=0, period_count increments, one pulse.
  - clear_error -> 0; simultaneous clear_error and new misaligned edge -> stays 1.
- Control priority:
  - resync with sample_valid at len-1 -> period_count=0, single pulse (internal mode).
  - enable=0 coincident with a boundary sample -> no pulse, IDLE, counters 0.
  - period_count wrap with CNT_W=4 after 16 periods -> 0.
